// File: rtl/keypad_number_entry.sv
`default_nettype none
// ============================================================================
// Module   : keypad_number_entry
// Purpose  : Turns debounced keypad presses into a decimal operand. Entered
//            digits are kept as BCD for the display decoders; ENTER converts
//            them, most significant digit first, to a 20-bit binary operand.
// Ports    :
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   key_press    in   raw asynchronous key-down level
//   key_code     in   raw key code (0-9 digit, 10 BKSP, 11 ENTER, 12 CLEAR)
//   digit_bcd    out  BCD digits, [3:0] least significant
//   digit_count  out  number of digits entered
//   busy         out  high while converting
//   value        out  binary operand from the last ENTER
//   value_valid  out  one-cycle pulse when value updates
//   entry_error  out  one-cycle pulse when a digit is rejected (entry full)
// Revision : 1.0 - initial release
// ============================================================================
module keypad_number_entry #(
  parameter int NUM_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    key_press,
  input  logic [3:0]              key_code,
  output logic [4*NUM_DIGITS-1:0] digit_bcd,
  output logic [2:0]              digit_count,
  output logic                    busy,
  output logic [19:0]             value,
  output logic                    value_valid,
  output logic                    entry_error
);

  // Debounce counter only needs to reach DEBOUNCE_CYCLES-1; the flip happens
  // on the cycle that would make it DEBOUNCE_CYCLES.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]       MAX_COUNT = 3'(NUM_DIGITS);
  localparam logic [2:0]       TOP_IDX   = 3'(NUM_DIGITS - 1);

  localparam logic [3:0] KEY_BKSP  = 4'd10;
  localparam logic [3:0] KEY_ENTER = 4'd11;
  localparam logic [3:0] KEY_CLEAR = 4'd12;

  typedef enum logic [0:0] {
    ST_ENTRY   = 1'b0,
    ST_CONVERT = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Synchronizer and debouncer
  // --------------------------------------------------------------------------
  logic             press_s1, press_s2;
  logic [3:0]       code_s1, code_s2;
  logic             accepted;
  logic [CNT_W-1:0] db_cnt;
  logic             key_event;
  logic [3:0]       event_code;

  always_ff @(posedge clk) begin
    if (rst) begin
      press_s1   <= 1'b0;
      press_s2   <= 1'b0;
      code_s1    <= 4'd0;
      code_s2    <= 4'd0;
      accepted   <= 1'b0;
      db_cnt     <= '0;
      key_event  <= 1'b0;
      event_code <= 4'd0;
    end else begin
      press_s1  <= key_press;
      press_s2  <= press_s1;
      code_s1   <= key_code;
      code_s2   <= code_s1;
      key_event <= 1'b0;
      if (press_s2 != accepted) begin
        if (db_cnt == CNT_LAST) begin
          accepted <= press_s2;
          db_cnt   <= '0;
          // Only the press edge is an event; releases just re-arm.
          if (press_s2) begin
            key_event  <= 1'b1;
            event_code <= code_s2;
          end
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Entry / conversion FSM
  // --------------------------------------------------------------------------
  state_t                  state, state_n;
  logic [4*NUM_DIGITS-1:0] bcd, bcd_n;
  logic [2:0]              count, count_n;
  logic                    fresh, fresh_n;
  logic [19:0]             acc, acc_n;
  logic [2:0]              idx, idx_n;
  logic [19:0]             value_n;
  logic                    valid_n;
  logic                    error_n;
  logic [3:0]              cur_digit;
  logic [19:0]             mac;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_ENTRY;
      bcd         <= '0;
      count       <= 3'd0;
      fresh       <= 1'b0;
      acc         <= 20'd0;
      idx         <= 3'd0;
      value       <= 20'd0;
      value_valid <= 1'b0;
      entry_error <= 1'b0;
    end else begin
      state       <= state_n;
      bcd         <= bcd_n;
      count       <= count_n;
      fresh       <= fresh_n;
      acc         <= acc_n;
      idx         <= idx_n;
      value       <= value_n;
      value_valid <= valid_n;
      entry_error <= error_n;
    end
  end

  always_comb begin
    state_n   = state;
    bcd_n     = bcd;
    count_n   = count;
    fresh_n   = fresh;
    acc_n     = acc;
    idx_n     = idx;
    value_n   = value;
    valid_n   = 1'b0;
    error_n   = 1'b0;
    cur_digit = 4'd0;

    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == 3'(i)) cur_digit = bcd[4*i +: 4];
    end
    // acc*10 as (acc<<3)+(acc<<1), wrapping at 20 bits.
    mac = {acc[16:0], 3'b000} + {acc[18:0], 1'b0} + {16'd0, cur_digit};

    case (state)
      ST_ENTRY: begin
        if (key_event) begin
          case (event_code)
            KEY_BKSP: begin
              bcd_n   = bcd >> 4;
              count_n = (count != 3'd0) ? count - 3'd1 : 3'd0;
              fresh_n = 1'b0;
            end
            KEY_ENTER: begin
              state_n = ST_CONVERT;
              acc_n   = 20'd0;
              idx_n   = TOP_IDX;
            end
            KEY_CLEAR: begin
              bcd_n   = '0;
              count_n = 3'd0;
              fresh_n = 1'b0;
            end
            default: begin
              if (event_code < 4'd10) begin
                if (fresh) begin
                  // First digit after a conversion starts a new operand.
                  bcd_n       = '0;
                  bcd_n[3:0]  = event_code;
                  count_n     = 3'd1;
                  fresh_n     = 1'b0;
                end else if (count < MAX_COUNT) begin
                  for (int i = NUM_DIGITS - 1; i > 0; i--) begin
                    bcd_n[4*i +: 4] = bcd[4*(i-1) +: 4];
                  end
                  bcd_n[3:0] = event_code;
                  count_n    = count + 3'd1;
                end else begin
                  error_n = 1'b1;
                end
              end
            end
          endcase
        end
      end

      ST_CONVERT: begin
        // Key events arriving here are dropped on purpose.
        acc_n = mac;
        idx_n = idx - 3'd1;
        if (idx == 3'd0) begin
          idx_n   = 3'd0;
          value_n = mac;
          valid_n = 1'b1;
          fresh_n = 1'b1;
          state_n = ST_ENTRY;
        end
      end

      default: state_n = ST_ENTRY;
    endcase
  end

  assign digit_bcd   = bcd;
  assign digit_count = count;
  assign busy        = (state == ST_CONVERT);

endmodule
`default_nettype wire

// File: tb/tb_keypad_number_entry.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_number_entry
// Purpose  : Directed self-checking bench for keypad_number_entry. A second
//            instance with single-cycle debounce lets key events land inside
//            the conversion window.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_number_entry;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_press = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic [15:0] digit_bcd;
  logic [2:0]  digit_count;
  logic        busy;
  logic [19:0] value;
  logic        value_valid;
  logic        entry_error;

  logic        f_press = 1'b0;
  logic [3:0]  f_code = 4'd0;
  logic [15:0] f_bcd;
  logic [2:0]  f_count;
  logic        f_busy;
  logic [19:0] f_value;
  logic        f_valid;
  logic        f_error;

  int checks = 0;
  int fails  = 0;

  int cyc = 0;
  int vv_count = 0;
  int vv_cyc = 0;
  int err_count = 0;
  int busy_cycles = 0;
  int busy_first = 0;
  int f_vv_count = 0;

  always #5 clk = ~clk;

  keypad_number_entry #(.NUM_DIGITS(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .key_press(key_press), .key_code(key_code),
    .digit_bcd(digit_bcd), .digit_count(digit_count), .busy(busy),
    .value(value), .value_valid(value_valid), .entry_error(entry_error)
  );

  keypad_number_entry #(.NUM_DIGITS(4), .DEBOUNCE_CYCLES(1)) dut_fast (
    .clk(clk), .rst(rst), .key_press(f_press), .key_code(f_code),
    .digit_bcd(f_bcd), .digit_count(f_count), .busy(f_busy),
    .value(f_value), .value_valid(f_valid), .entry_error(f_error)
  );

  // Pulse observers, sampled on the falling edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (value_valid) begin
      vv_count = vv_count + 1;
      vv_cyc   = cyc;
    end
    if (entry_error) err_count = err_count + 1;
    if (busy) begin
      if (busy_cycles == 0) busy_first = cyc;
      busy_cycles = busy_cycles + 1;
    end
    if (f_valid) f_vv_count = f_vv_count + 1;
  end

  task automatic clear_obs();
    vv_count = 0; err_count = 0; busy_cycles = 0; f_vv_count = 0;
  endtask

  task automatic press(input logic [3:0] code);
    key_code = code;
    key_press = 1'b1;
    repeat (10) @(posedge clk);
    #1 key_press = 1'b0;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    clear_obs();
    @(posedge clk); #1;
    checks++; if (digit_bcd !== 16'h0000) begin fails++; $display("FAIL reset_bcd got %h want 0000", digit_bcd); end
    checks++; if (digit_count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d want 0", digit_count); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (value !== 20'd0) begin fails++; $display("FAIL reset_value got %0d want 0", value); end
    checks++; if ({value_valid, entry_error} !== 2'b00) begin fails++; $display("FAIL reset_pulses got %b want 00", {value_valid, entry_error}); end
  endtask

  task automatic test_digits();
    clear_obs();
    press(4'd2); press(4'd3); press(4'd4); press(4'd5);
    checks++; if (digit_bcd !== 16'h2345) begin fails++; $display("FAIL digits_bcd got %h want 2345", digit_bcd); end
    checks++; if (digit_count !== 3'd4) begin fails++; $display("FAIL digits_count got %0d want 4", digit_count); end
    checks++; if (err_count !== 0) begin fails++; $display("FAIL digits_err got %0d want 0", err_count); end
  endtask

  task automatic test_enter();
    clear_obs();
    press(4'd11);
    checks++; if (busy_cycles !== 4) begin fails++; $display("FAIL enter_busy_cycles got %0d want 4", busy_cycles); end
    checks++; if (vv_count !== 1) begin fails++; $display("FAIL enter_vv_count got %0d want 1", vv_count); end
    checks++; if (vv_cyc - busy_first !== 4) begin fails++; $display("FAIL enter_latency got %0d want 4", vv_cyc - busy_first); end
    checks++; if (value !== 20'd2345) begin fails++; $display("FAIL enter_value got %0d want 2345", value); end
    press(4'd6);
    checks++; if (digit_bcd !== 16'h0006) begin fails++; $display("FAIL fresh_bcd got %h want 0006", digit_bcd); end
    checks++; if (digit_count !== 3'd1) begin fails++; $display("FAIL fresh_count got %0d want 1", digit_count); end
  endtask

  task automatic test_full();
    clear_obs();
    press(4'd7); press(4'd8); press(4'd9);
    checks++; if (err_count !== 0) begin fails++; $display("FAIL full_early_err got %0d want 0", err_count); end
    press(4'd1);
    checks++; if (err_count !== 1) begin fails++; $display("FAIL full_err got %0d want 1", err_count); end
    checks++; if (digit_bcd !== 16'h6789) begin fails++; $display("FAIL full_bcd got %h want 6789", digit_bcd); end
    checks++; if (digit_count !== 3'd4) begin fails++; $display("FAIL full_count got %0d want 4", digit_count); end
    press(4'd10);
    checks++; if (digit_bcd !== 16'h0678) begin fails++; $display("FAIL bksp_bcd got %h want 0678", digit_bcd); end
    checks++; if (digit_count !== 3'd3) begin fails++; $display("FAIL bksp_count got %0d want 3", digit_count); end
    press(4'd11);
    checks++; if (value !== 20'd678) begin fails++; $display("FAIL bksp_value got %0d want 678", value); end
  endtask

  task automatic test_bounce();
    press(4'd12);
    checks++; if (digit_count !== 3'd0) begin fails++; $display("FAIL clear_count got %0d want 0", digit_count); end
    press(4'd3);
    key_code = 4'd5;
    for (int i = 0; i < 5; i++) begin
      key_press = 1'b1;
      repeat (2) @(posedge clk);
      #1 key_press = 1'b0;
      @(posedge clk); #1;
    end
    key_press = 1'b1;
    repeat (10) @(posedge clk);
    #1 key_press = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (digit_bcd !== 16'h0035) begin fails++; $display("FAIL bounce_bcd got %h want 0035", digit_bcd); end
    checks++; if (digit_count !== 3'd2) begin fails++; $display("FAIL bounce_count got %0d want 2", digit_count); end
  endtask

  task automatic test_busy_keys();
    bit seen;
    press(4'd12);
    press(4'd1);
    clear_obs();
    key_code = 4'd11;
    key_press = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    checks++; if (!seen) begin fails++; $display("FAIL held_busy_timeout got 0 want 1"); end
    key_code = 4'd9;   // key stays down across the end of conversion
    repeat (30) @(posedge clk);
    #1 key_press = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (value !== 20'd1) begin fails++; $display("FAIL held_value got %0d want 1", value); end
    checks++; if (vv_count !== 1) begin fails++; $display("FAIL held_vv_count got %0d want 1", vv_count); end
    checks++; if (digit_bcd !== 16'h0001) begin fails++; $display("FAIL held_bcd got %h want 0001", digit_bcd); end
    press(4'd12);
    checks++; if (value !== 20'd1) begin fails++; $display("FAIL clear_keeps_value got %0d want 1", value); end
    press(4'd11);
    checks++; if (value !== 20'd0) begin fails++; $display("FAIL empty_enter_value got %0d want 0", value); end
    checks++; if (vv_count !== 2) begin fails++; $display("FAIL empty_enter_vv got %0d want 2", vv_count); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    press(4'd4);
    press(4'd11);
    checks++; if (value !== 20'd4) begin fails++; $display("FAIL pre_reset_value got %0d want 4", value); end
    press(4'd5);
    clear_obs();
    key_code = 4'd11;
    key_press = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    checks++; if (!seen) begin fails++; $display("FAIL mid_busy_timeout got 0 want 1"); end
    key_press = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (value !== 20'd0) begin fails++; $display("FAIL mid_value got %0d want 0", value); end
    checks++; if (digit_count !== 3'd0) begin fails++; $display("FAIL mid_count got %0d want 0", digit_count); end
    checks++; if ({busy, value_valid, entry_error, digit_bcd} !== 19'd0) begin fails++; $display("FAIL mid_outputs got %h want 0", {busy, value_valid, entry_error, digit_bcd}); end
    repeat (15) @(posedge clk);
    #1;
    checks++; if (vv_count !== 0) begin fails++; $display("FAIL mid_vv_count got %0d want 0", vv_count); end
  endtask

  task automatic test_drop_fast();
    clear_obs();
    f_code = 4'd1; f_press = 1'b1;
    @(posedge clk); #1 f_press = 1'b0;
    repeat (3) @(posedge clk); #1;
    f_code = 4'd11; f_press = 1'b1;
    @(posedge clk); #1 f_press = 1'b0;
    @(posedge clk); #1;
    f_code = 4'd9; f_press = 1'b1;   // event lands two cycles into CONVERT
    @(posedge clk); #1 f_press = 1'b0;
    repeat (12) @(posedge clk); #1;
    checks++; if (f_value !== 20'd1) begin fails++; $display("FAIL drop_value got %0d want 1", f_value); end
    checks++; if (f_bcd !== 16'h0001) begin fails++; $display("FAIL drop_bcd got %h want 0001", f_bcd); end
    checks++; if (f_count !== 3'd1) begin fails++; $display("FAIL drop_count got %0d want 1", f_count); end
    checks++; if (f_vv_count !== 1) begin fails++; $display("FAIL drop_vv_count got %0d want 1", f_vv_count); end
  endtask

  initial begin
    test_reset();
    test_digits();
    test_enter();
    test_full();
    test_bounce();
    test_busy_keys();
    test_reset_mid();
    test_drop_fast();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/keypad_number_entry.md
Name: keypad_number_entry

Overview:
- Input-side counterpart of the result display path: turns debounced keypad presses into a decimal operand.
- Keeps the entered digits as BCD for the seven-segment digit decoders.
- On ENTER, converts the BCD digits to a 20-bit binary operand for the calculator datapath.
- Sits between the board keypad/pushbuttons and the operand registers of the ALU.

Parameters:
- NUM_DIGITS, 4, number of decimal digits held; legal range 1..6, since 999999 < 2^20.
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized cycles required to accept a press or release; use 1000000 on hardware.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- key_press  in  1  raw asynchronous key-down level.
- key_code  in  4  raw key code; 0-9 digit, 10 BACKSPACE, 11 ENTER, 12 CLEAR, 13-15 ignored.
- digit_bcd  out  4*NUM_DIGITS  BCD digits; [3:0] is the least significant digit; unused positions are 0.
- digit_count  out  3  number of digits entered, 0..NUM_DIGITS.
- busy  out  1  high while in CONVERT.
- value  out  20  binary operand from the last ENTER.
- value_valid  out  1  one-cycle pulse when value updates.
- entry_error  out  1  one-cycle pulse when a digit is rejected because the entry is full.

Behaviour:
- Reset: all outputs 0, state ENTRY, synchronizers and debouncer cleared, fresh=0.
- Synchronizer: key_press and key_code each pass through 2 flip-flops.
- Debouncer:
  - Counts cycles the synchronized press level differs from the accepted level.
  - Any return to the accepted level resets the count.
  - When the count reaches DEBOUNCE_CYCLES, the accepted level flips.
  - A 0->1 flip generates key_event for one cycle, with key_code latched from the synchronized code in the same cycle.
  - Exactly one event per press. Bounces shorter than DEBOUNCE_CYCLES produce no event.
- FSM state ENTRY, on key_event (cycle E). Effects are visible at E+1.
  - Digit, fresh=1: clear all digits, load digit into position 0, count=1, fresh=0.
  - Digit, count<NUM_DIGITS: shift digits up one position, new digit into position 0, count+1.
  - Digit, count==NUM_DIGITS: digits unchanged, entry_error pulses at E+1.
  - BACKSPACE: shift digits down one position, top position=0, count-1 saturating at 0; fresh=0.
  - CLEAR: all digits 0, count=0, fresh=0. value is not changed.
  - ENTER: go to CONVERT; acc=0, idx=NUM_DIGITS-1.
  - Codes 13-15: no effect.
- FSM state CONVERT:
  - busy=1.
  - Each cycle: acc = acc*10 + digit[idx], with acc*10 computed as (acc<<3)+(acc<<1), truncated to 20 bits; then idx decrements.
  - Runs exactly NUM_DIGITS cycles, most significant digit first.
  - Leading zero digits contribute 0.
  - On exit: value=final acc, value_valid=1 for one cycle, fresh=1, return to ENTRY.
- Latency: ENTER event at E gives value_valid high at cycle E+NUM_DIGITS+1. For NUM_DIGITS=4 that is E+5.
- Keys during CONVERT: key_events are dropped, not queued. The debouncer keeps running, so a key held across the end of CONVERT produces no second event.
- ENTER with count=0: value=0, value_valid pulses.
- Reset mid-CONVERT: aborts the conversion. No value_valid pulse; value=0.
- Reset has priority over every event in the same cycle.
- digit_bcd holds valid BCD 0-9 at all times.

Test Plan:
- Reset, then press 2,3,4,5 with clean presses held 10 cycles and 10-cycle gaps -> digit_bcd=0x2345, count=4, no entry_error.
- From that state press ENTER -> busy for 4 cycles, value_valid at E+5, value=2345 (0x00929); next press 6 -> digit_bcd=0x0006, count=1 (fresh restart).
- Press 6,7,8,9 then 1 -> entry_error pulse on the 5th press, digit_bcd stays 0x6789. Then BACKSPACE -> 0x0678, count=3. Then ENTER -> value=678.
- Bounce: key_press toggles high 2 cycles, low 1 cycle, repeated 5 times, then held high 10 cycles -> exactly one digit appended.
- Press 1, press ENTER, and press 9 during busy -> 9 ignored, value=1; also CLEAR then ENTER -> value=0 with a value_valid pulse.
- Assert rst for 1 cycle at E+2 after an ENTER -> no value_valid, all outputs 0 next cycle, count=0.
